spi_slave_port: RTL



---
 rtl/spi_slave_port.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave_port.sv
// SPI slave endpoint: oversampled SCLK/SS_n/MOSI, all CPOL/CPHA modes,
// MSB-first full-duplex words, one-deep transmit holding buffer.
module spi_slave_port #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             CPOL,
  input  logic             CPHA,
  input  logic             SCLK,
  input  logic             SS_n,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] TxData,
  input  logic             TxLoad,
  output logic             TxReady,
  output logic [WIDTH-1:0] RxData,
  output logic             RxValid,
  output logic             Busy,
  output logic             Underrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state;
  state_t           nextState;
  logic             startWord;
  logic [2:0]       sclkSync;
  logic [1:0]       ssSync;
  logic [1:0]       mosiSync;
  logic             ssPrev;
  logic             ssS;
  logic             ssFall;
  logic             mosiS;
  logic             cpolQ;
  logic             cphaQ;
  logic             riseEdge;
  logic             fallEdge;
  logic             leadEdge;
  logic             trailEdge;
  logic             inXfer;
  logic             sampleEdge;
  logic             shiftEdge;
  logic [WIDTH-1:0] txBuf;
  logic [WIDTH-1:0] txShift;
  logic [WIDTH-2:0] rxShift;
  logic [CW-1:0]    bitCount;
  logic             holdShift;

  assign ssS       = ssSync[1];
  assign mosiS     = mosiSync[1];
  assign ssFall    = ssPrev & ~ssS;
  assign riseEdge  = sclkSync[1] & ~sclkSync[2];
  assign fallEdge  = ~sclkSync[1] & sclkSync[2];
  assign leadEdge  = cpolQ ? fallEdge : riseEdge;
  assign trailEdge = cpolQ ? riseEdge : fallEdge;
  assign inXfer    = (state == ACTIVE) && !ssS;
  assign sampleEdge = inXfer && (cphaQ ? trailEdge : leadEdge);
  assign shiftEdge  = inXfer && (cphaQ ? leadEdge : trailEdge);

  assign Busy = (state == ACTIVE);
  assign MISO = (state == ACTIVE) ? txShift[WIDTH-1] : 1'b0;

  // Synchronisers; select resets as "low" so a reset mid-transfer needs a fresh SS_n high-then-low.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      sclkSync <= '0;
      ssSync   <= '0;
      mosiSync <= '0;
      ssPrev   <= 1'b0;
    end else begin
      sclkSync <= {sclkSync[1:0], SCLK};
      ssSync   <= {ssSync[0], SS_n};
      mosiSync <= {mosiSync[0], MOSI};
      ssPrev   <= ssSync[1];
    end
  end

  // Capture the SPI mode when the select is first seen asserted.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      cpolQ <= 1'b0;
      cphaQ <= 1'b0;
    end else if (state == IDLE && ssFall) begin
      cpolQ <= CPOL;
      cphaQ <= CPHA;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state and word-start decision.
  always_comb begin
    nextState = state;
    startWord = 1'b0;
    case (state)
      IDLE: begin
        if (ssFall) begin
          nextState = ACTIVE;
          startWord = 1'b1;
        end
      end
      ACTIVE: begin
        if (ssS) begin
          nextState = IDLE;
        end else if (sampleEdge && bitCount == LAST) begin
          startWord = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Holding buffer, shift registers, bit counter and the pulse outputs.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      txBuf     <= '0;
      TxReady   <= 1'b1;
      txShift   <= '0;
      rxShift   <= '0;
      bitCount  <= '0;
      holdShift <= 1'b0;
      RxData    <= '0;
      RxValid   <= 1'b0;
      Underrun  <= 1'b0;
    end else begin
      RxValid  <= 1'b0;
      Underrun <= 1'b0;
      if (startWord && !TxReady) begin
        TxReady <= 1'b1;
      end else if (TxLoad && TxReady) begin
        txBuf   <= TxData;
        TxReady <= 1'b0;
      end
      if (sampleEdge) begin
        rxShift <= {rxShift[WIDTH-3:0], mosiS};
        if (bitCount == LAST) begin
          RxData  <= {rxShift, mosiS};
          RxValid <= 1'b1;
        end else begin
          bitCount <= bitCount + 1'b1;
        end
      end
      if (startWord) begin
        bitCount  <= '0;
        txShift   <= TxReady ? '0 : txBuf;
        Underrun  <= TxReady;
        holdShift <= (state == ACTIVE) ? 1'b1 : CPHA;
      end else if (shiftEdge) begin
        if (holdShift) begin
          holdShift <= 1'b0;
        end else begin
          txShift <= {txShift[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule
